gemm_operand_loader: RTL
========================

# gemm_operand_loader

Upstream feeder for the `gemm` compute stage. It accepts a single stream of matrix elements over a valid/ready handshake. It fills two on-chip operand buffers, matrix A then matrix B, each row-major, MATRIX_SIZE×MATRIX_SIZE. It then pulses `gemm_start`, holds off new input until the compute stage reports `gemm_done`, and serves both buffers through combinational read ports.

## Interface
- DATA_WIDTH, 16, element width in bits
- ADDR_WIDTH, 16, read-address width; must satisfy 2^ADDR_WIDTH ≥ MATRIX_SIZE²
- MATRIX_SIZE, 32, matrix dimension N; buffers hold N² elements each

Ports:
- clk  input  1  rising-edge clock, the only clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  `in_data` is valid this cycle
- in_ready  output  1  loader accepts an element this cycle
- in_data  input  DATA_WIDTH  element; A elements first, then B elements, row-major
- gemm_start  output  1  one-cycle pulse: both buffers are full
- gemm_done  input  1  compute stage finished; sampled only in WAIT
- rd_addr_a  input  ADDR_WIDTH  A buffer read index, i*N+k
- rd_data_a  output  DATA_WIDTH  A[rd_addr_a], combinational
- rd_addr_b  input  ADDR_WIDTH  B buffer read index, k*N+j
- rd_data_b  output  DATA_WIDTH  B[rd_addr_b], combinational
- busy  output  1  high in START and WAIT
- load_count  output  ADDR_WIDTH+1  number of elements accepted in the current pass, 0..2N²

## Operation
- States: LOAD_A, LOAD_B, START, WAIT. The reset state is LOAD_A.
- Transfer rule: an element is transferred on a rising edge where `in_valid && in_ready`. `in_ready` = 1 only in LOAD_A and LOAD_B.
- Element index `idx`:
  - Counts 0..N²−1.
  - Increments on each transfer.
  - Wraps to 0 after N²−1.
- LOAD_A:
  - Each transfer writes A[idx] ← in_data.
  - The transfer at idx = N²−1 moves the state to LOAD_B.
- LOAD_B:
  - Each transfer writes B[idx] ← in_data.
  - The transfer at idx = N²−1 moves the state to START.
- START:
  - `gemm_start` = 1 for exactly this one cycle.
  - Unconditionally moves to WAIT.
- WAIT:
  - Stays in WAIT while `gemm_done` = 0.
  - `gemm_done` = 1 sampled at an edge moves the state to LOAD_A and clears `load_count` to 0.
- `load_count`:
  - Increments on each transfer and saturates at 2N².
  - Holds its value through START and WAIT.
- Buffers:
  - Writes are synchronous.
  - Reads are asynchronous.
  - Reading an address in the same cycle it is written returns the old contents; the new value is visible after the edge.
  - Out-of-range read addresses (≥ N²) return 0.
- Buffer contents persist across passes and are overwritten element by element. Reset does not clear them; their contents after reset are undefined until rewritten.
- Input stalls: `in_valid` low holds all state. There is no timeout.

## Timing
- Reset values:
  - `in_ready` = 1 (state LOAD_A)
  - `gemm_start` = 0, `busy` = 0, `load_count` = 0
  - `idx` = 0
- Reset asserted mid-load or in WAIT:
  - Takes effect immediately and asynchronously.
  - Any partially loaded pass is discarded; the next accepted element is A[0].
  - `gemm_start` is never emitted for the discarded pass.
- Latency: `gemm_start` is asserted in the cycle immediately after the edge that accepts the last B element (B[N²−1]).
- Minimum pass length: 2N² transfer cycles + 1 (START) + 1 (minimum WAIT) cycles. With back-to-back input, `in_ready` is low for at least 2 cycles between passes.
- `gemm_done` asserted during START or LOAD_* is ignored, not latched.
- `gemm_done` held high for multiple cycles causes a single exit from WAIT. A new `gemm_start` requires a full 2N² load.
- `busy` rises together with `gemm_start` and falls on the edge that leaves WAIT.

## Test plan
- N=2, reset released, stream A=1,2,3,4 and B=5,6,7,8 with `in_valid` continuously high.
  - `in_ready` high for 8 cycles.
  - `gemm_start` pulses once in cycle 9.
  - `rd_data_a` at address 2 = 3; `rd_data_b` at address 3 = 8; `load_count` = 8.
- Same stream with `in_valid` toggled 1,0,1,0.
  - Identical buffer contents.
  - `gemm_start` one cycle after the 8th accepted element.
  - `load_count` never counts idle cycles.
- In WAIT, hold `gemm_done` = 0 for 20 cycles, then pulse it once.
  - `in_ready` stays 0 throughout the wait.
  - After the pulse, `busy` = 0, `in_ready` = 1, `load_count` = 0.
  - A second pass with A=9..12 overwrites A; `rd_data_a[0]` = 9.
- Assert `reset` after 5 accepted elements (mid-B).
  - `in_ready` = 1, `load_count` = 0, no `gemm_start`.
  - The next 8 elements fill A then B from index 0.
- Drive `gemm_done` = 1 during LOAD_A and START.
  - No state change.
  - The loader still waits in WAIT until a later `gemm_done`.
- Read with `rd_addr_a` = 4 (N=2): `rd_data_a` = 0.

Source files
------------

// File: rtl/gemm_operand_loader_if.sv
// Element stream into the GEMM operand loader.
// An element moves on a rising clk edge where in_valid && in_ready. The master holds in_data
// stable while in_valid is high and not yet accepted. in_ready does not depend on in_valid.
interface gemm_operand_loader_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/gemm_operand_loader.sv
// Fills operand buffers A then B from one element stream, pulses gemm_start,
// then holds off input until gemm_done. Both buffers have combinational read ports.
module gemm_operand_loader #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 16,
    parameter int MATRIX_SIZE = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    gemm_operand_loader_if.slave  in_if,
    output logic                  gemm_start,
    input  logic                  gemm_done,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic [DATA_WIDTH-1:0] rd_data_b,
    output logic                  busy,
    output logic [ADDR_WIDTH:0]   load_count,
    output logic [1:0]            dbg_state
);
    localparam int DEPTH = MATRIX_SIZE * MATRIX_SIZE;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] COUNT_MAX = (ADDR_WIDTH + 1)'(2 * DEPTH);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        START  = 2'd2,
        WAIT   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q;
    logic                  xfer;
    logic                  last_elem;
    logic [DATA_WIDTH-1:0] mem_a [DEPTH];
    logic [DATA_WIDTH-1:0] mem_b [DEPTH];

    assign xfer      = in_if.in_valid && in_if.in_ready;
    assign last_elem = (idx_q == IDX_LAST);
    assign dbg_state = state_q;

    always_comb begin
        state_d        = state_q;
        in_if.in_ready = 1'b0;
        gemm_start     = 1'b0;
        busy           = 1'b0;
        case (state_q)
            LOAD_A: begin
                in_if.in_ready = 1'b1;
                if (in_if.in_valid && last_elem) state_d = LOAD_B;
            end
            LOAD_B: begin
                in_if.in_ready = 1'b1;
                if (in_if.in_valid && last_elem) state_d = START;
            end
            START: begin
                gemm_start = 1'b1;
                busy       = 1'b1;
                state_d    = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (gemm_done) state_d = LOAD_A;
            end
            default: state_d = LOAD_A;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= LOAD_A;
            idx_q      <= '0;
            load_count <= '0;
        end else begin
            state_q <= state_d;
            if (xfer) begin
                idx_q <= last_elem ? '0 : idx_q + 1'b1;
                if (load_count != COUNT_MAX) load_count <= load_count + 1'b1;
            end
            // Leaving WAIT starts a fresh pass; idx has already wrapped to 0.
            if (state_q == WAIT && gemm_done) load_count <= '0;
        end
    end

    // Buffers are deliberately not reset; contents persist across passes.
    always_ff @(posedge clk) begin
        if (xfer && state_q == LOAD_A) mem_a[idx_q] <= in_if.in_data;
        if (xfer && state_q == LOAD_B) mem_b[idx_q] <= in_if.in_data;
    end

    always_comb begin
        rd_data_a = '0;
        rd_data_b = '0;
        if ({1'b0, rd_addr_a} < DEPTH_W) rd_data_a = mem_a[rd_addr_a[IDX_W-1:0]];
        if ({1'b0, rd_addr_b} < DEPTH_W) rd_data_b = mem_b[rd_addr_b[IDX_W-1:0]];
    end
endmodule
